// File: rtl/btn_if.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_if: raw button pads in, debounced levels and press pulses out.
// Rev 1.0
// ------------------------------------------------------------------
interface btn_if;
   logic btnl_raw;
   logic btnr_raw;
   logic btnl_pulse;
   logic btnr_pulse;
   logic btnl_level;
   logic btnr_level;

   modport master (
      output btnl_raw, btnr_raw,
      input  btnl_pulse, btnr_pulse, btnl_level, btnr_level
   );

   modport slave (
      input  btnl_raw, btnr_raw,
      output btnl_pulse, btnr_pulse, btnl_level, btnr_level
   );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------
// button_conditioner: sync + debounce of btnl/btnr with one-cycle press pulses;
// define BTN_AUTOREPEAT_EN to add held-button auto-repeat.  Rev 1.0
// ------------------------------------------------------------------
module button_conditioner #(
   parameter int DB_CYCLES     = 1_000_000,
   parameter int CNT_W         = 27,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic  clk,
   input  logic  rst,
   btn_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_DB_TERM = CNT_W'(DB_CYCLES);

   if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       (64'(DB_CYCLES) >> CNT_W) != 64'd0 ||
       (64'(REPEAT_DELAY) >> CNT_W) != 64'd0 ||
       (64'(REPEAT_PERIOD) >> CNT_W) != 64'd0) begin : g_bad_cfg
      $error("button_conditioner: cycle counts must be >= 1 and fit in CNT_W bits");
   end

   // Bit 0 is the left channel, bit 1 the right channel.
   logic [1:0] raw;
   logic [1:0] s1_q;
   logic [1:0] s2_q;
   logic [1:0] stable_q;
   logic [1:0] stable_d;
   logic [1:0] prev_q;
   logic [1:0] rise;
   logic [1:0] rep_fire;
   logic [1:0] pulse_q;
   logic [1:0] pulse_d;
   logic       l_evt;
   logic       r_evt;

   assign raw = {bus.btnr_raw, bus.btnl_raw};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         pulse_q  <= '0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         pulse_q  <= pulse_d;
      end
   end

   assign rise = stable_q & ~prev_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] c_DELAY_TERM  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] c_PERIOD_TERM = CNT_W'(REPEAT_PERIOD - 1);
`endif

   for (genvar i = 0; i < 2; i++) begin : g_chan
      logic [CNT_W-1:0] db_cnt_q;
      logic [CNT_W-1:0] db_cnt_d;
      logic             stable_nxt;

      // Acceptance happens once the mismatch has already been counted DB_CYCLES times.
      always_comb begin
         db_cnt_d   = '0;
         stable_nxt = stable_q[i];
         if (s2_q[i] != stable_q[i]) begin
            if (db_cnt_q == c_DB_TERM) begin
               stable_nxt = s2_q[i];
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_d;
         end
      end

      assign stable_d[i] = stable_nxt;

`ifdef BTN_AUTOREPEAT_EN
      logic [CNT_W-1:0] rep_cnt_q;
      logic [CNT_W-1:0] rep_cnt_d;
      logic             rep_first_q;
      logic             rep_first_d;
      logic             fire;

      // Counter tracks cycles since the last pulse; a level about to drop never fires.
      always_comb begin
         rep_cnt_d   = rep_cnt_q;
         rep_first_d = rep_first_q;
         fire        = 1'b0;
         if (!stable_q[i] || !stable_d[i] || rise[i]) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
         end else if (rep_cnt_q == (rep_first_q ? c_DELAY_TERM : c_PERIOD_TERM)) begin
            fire        = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
         end else if (rep_cnt_q != '1) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
         end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
         end
      end

      assign rep_fire[i] = fire;
`else
      assign rep_fire[i] = 1'b0;
`endif
   end

   // Left wins a same-cycle collision; the right event is dropped, not deferred.
   assign l_evt   = rise[0] | rep_fire[0];
   assign r_evt   = (rise[1] | rep_fire[1]) & ~l_evt;
   assign pulse_d = {r_evt, l_evt};

   assign bus.btnl_pulse = pulse_q[0];
   assign bus.btnr_pulse = pulse_q[1];
   assign bus.btnl_level = stable_q[0];
   assign bus.btnr_level = stable_q[1];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_button_conditioner: directed scenarios with a pulse scoreboard.
// Rev 1.0
// ------------------------------------------------------------------
module tb_button_conditioner;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   btn_if bus ();

   button_conditioner #(
      .DB_CYCLES     (4),
      .CNT_W         (8),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit ch;
      int edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   edge_cnt    = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   task automatic push(input bit ch, input int e);
      exp_t x;
      x.ch      = ch;
      x.edge_no = e;
      exp_q.push_back(x);
   endtask

   task automatic wait_edge(input int e);
      while (edge_cnt < e) @(negedge clk);
   endtask

   task automatic end_scn(input string name);
      chk({name, "_pending_pulses"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      bus.btnl_raw = 1'b0;
      bus.btnr_raw = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      chk("reset_level_l", int'(bus.btnl_level), 0);
      chk("reset_level_r", int'(bus.btnr_level), 0);
      chk("reset_pulse_l", int'(bus.btnl_pulse), 0);
      chk("reset_pulse_r", int'(bus.btnr_pulse), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Monitor: every observed pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      if (bus.btnl_pulse || bus.btnr_pulse) begin
         chk("pulse_exclusive", int'(bus.btnl_pulse & bus.btnr_pulse), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse_edge", edge_cnt, -1);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_channel", int'(bus.btnr_pulse), int'(e.ch));
            chk("pulse_edge", edge_cnt, e.edge_no);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at edge %0d", edge_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.btnl_raw = 1'b0;
      bus.btnr_raw = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      do_reset();

      // Clean press on the left button.
      bus.btnl_raw = 1'b1;
      base = edge_cnt + 1;
      push(1'b0, base + 7);
      wait_edge(base + 5);  chk("clean_level_pre",  int'(bus.btnl_level), 0);
      wait_edge(base + 6);  chk("clean_level_on",   int'(bus.btnl_level), 1);
      wait_edge(base + 19); bus.btnl_raw = 1'b0;
      wait_edge(base + 25); chk("clean_level_hold", int'(bus.btnl_level), 1);
      wait_edge(base + 26); chk("clean_level_off",  int'(bus.btnl_level), 0);
      wait_edge(base + 35); end_scn("clean");

      // Bouncing right button, then a steady hold.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         bus.btnr_raw = 1'b1;
         repeat (3) @(negedge clk);
         bus.btnr_raw = 1'b0;
         @(negedge clk);
      end
      bus.btnr_raw = 1'b1;
      base = edge_cnt + 1;
      push(1'b1, base + 7);
      wait_edge(base + 5);  chk("bounce_level_pre", int'(bus.btnr_level), 0);
      wait_edge(base + 6);  chk("bounce_level_on",  int'(bus.btnr_level), 1);
      wait_edge(base + 12); bus.btnr_raw = 1'b0;
      wait_edge(base + 22); end_scn("bounce");

      // Both buttons at once: left wins.
      do_reset();
      bus.btnl_raw = 1'b1;
      bus.btnr_raw = 1'b1;
      base = edge_cnt + 1;
      push(1'b0, base + 7);
      wait_edge(base + 5);
      chk("simul_level_l_pre", int'(bus.btnl_level), 0);
      chk("simul_level_r_pre", int'(bus.btnr_level), 0);
      wait_edge(base + 6);
      chk("simul_level_l_on", int'(bus.btnl_level), 1);
      chk("simul_level_r_on", int'(bus.btnr_level), 1);
      wait_edge(base + 14); end_scn("simul");

      // Reset in the middle of a debounce.
      do_reset();
      bus.btnl_raw = 1'b1;
      base = edge_cnt + 1;
      push(1'b0, base + 15);
      wait_edge(base + 4);  rst = 1'b1;
      wait_edge(base + 6);  chk("rstmid_level_in_rst", int'(bus.btnl_level), 0);
      wait_edge(base + 7);  rst = 1'b0;
      wait_edge(base + 13); chk("rstmid_level_pre", int'(bus.btnl_level), 0);
      wait_edge(base + 14); chk("rstmid_level_on",  int'(bus.btnl_level), 1);
      wait_edge(base + 20); bus.btnl_raw = 1'b0;
      wait_edge(base + 30); end_scn("rstmid");

      // Long hold: repeats only when auto-repeat is built in.
      do_reset();
      bus.btnl_raw = 1'b1;
      base = edge_cnt + 1;
      push(1'b0, base + 7);
`ifdef BTN_AUTOREPEAT_EN
      for (int t = 17; t <= 35; t += 3) push(1'b0, base + t);
`endif
      wait_edge(base + 29); bus.btnl_raw = 1'b0;
      wait_edge(base + 35); chk("hold_level_last", int'(bus.btnl_level), 1);
      wait_edge(base + 36); chk("hold_level_off",  int'(bus.btnl_level), 0);
      wait_edge(base + 45); end_scn("hold");

      // Glitch too short to be accepted.
      do_reset();
      bus.btnr_raw = 1'b1;
      base = edge_cnt + 1;
      wait_edge(base + 2); bus.btnr_raw = 1'b0;
      for (int t = 3; t <= 12; t++) begin
         wait_edge(base + t);
         chk("glitch_level", int'(bus.btnr_level), 0);
      end
      end_scn("glitch");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
